// File: rtl/fp_accum_initiator_pkg.sv
// Shared definitions for the FP accumulation initiator: state encoding, word width and
// a few IEEE-754 single-precision constants.
package fp_accum_initiator_pkg;

    localparam int unsigned FP_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_ACCEPT = 2'd0;
    localparam state_t ST_SEND   = 2'd1;
    localparam state_t ST_WAIT_Z = 2'd2;
    localparam state_t ST_EMIT   = 2'd3;

    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;
    localparam logic [FP_W-1:0] FP_SIX   = 32'h40C0_0000;

endpackage

// File: rtl/fp_accum_initiator_stb_port.sv
// One-word stb/ack output holder: keeps the word stable while its strobe is up and
// remembers that its transfer has completed until the pair is retired.
module fp_stb_port
    import fp_accum_initiator_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [FP_W-1:0] load_data,
    input  logic            active,
    input  logic            clear,
    input  logic            ack,
    output logic [FP_W-1:0] data,
    output logic            stb,
    output logic            done,
    output logic            xfer
);

    logic [FP_W-1:0] data_q;
    logic            done_q;

    assign stb  = active & ~done_q;
    assign xfer = stb & ack;
    assign data = data_q;
    assign done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (load) begin
                data_q <= load_data;
            end
            // Retiring the pair wins over a same-edge transfer so the next pair starts clean.
            if (clear) begin
                done_q <= 1'b0;
            end else if (xfer) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_accum_initiator.sv
// Sums groups of single-precision values by driving (running_sum, element) pairs into a
// shared stb/ack FP adder, then presents one sum and element count per group.
module fp_accum_initiator
    import fp_accum_initiator_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [FP_W-1:0]  adder_a,
    output logic             adder_a_stb,
    input  logic             adder_a_ack,
    output logic [FP_W-1:0]  adder_b,
    output logic             adder_b_stb,
    input  logic             adder_b_ack,
    input  logic [FP_W-1:0]  adder_z,
    input  logic             adder_z_stb,
    output logic             adder_z_ack,
    output logic [FP_W-1:0]  sum_data,
    output logic [CNT_W-1:0] sum_count,
    output logic             sum_valid,
    input  logic             sum_ready
);

    state_t           state_q, state_d;
    logic             first_q;
    logic             last_q;
    logic [FP_W-1:0]  acc_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;

    logic in_xfer, z_xfer, sum_xfer;
    logic send, load_pair, pair_done;
    logic a_done, a_xfer, b_done, b_xfer;

    assign in_ready    = (state_q == ST_ACCEPT);
    assign adder_z_ack = (state_q == ST_WAIT_Z);
    assign sum_valid   = (state_q == ST_EMIT);
    assign sum_data    = acc_q;
    assign sum_count   = cnt_q;

    assign send      = (state_q == ST_SEND);
    assign in_xfer   = in_valid & in_ready;
    assign z_xfer    = adder_z_stb & adder_z_ack;
    assign sum_xfer  = sum_valid & sum_ready;
    assign load_pair = in_xfer & ~first_q;
    // Both halves of the pair are complete once each has transferred, possibly on this edge.
    assign pair_done = send & (a_done | a_xfer) & (b_done | b_xfer);

    assign cnt_inc = first_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));

    fp_stb_port u_port_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load_pair),
        .load_data (acc_q),
        .active    (send),
        .clear     (pair_done),
        .ack       (adder_a_ack),
        .data      (adder_a),
        .stb       (adder_a_stb),
        .done      (a_done),
        .xfer      (a_xfer)
    );

    fp_stb_port u_port_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load_pair),
        .load_data (in_data),
        .active    (send),
        .clear     (pair_done),
        .ack       (adder_b_ack),
        .data      (adder_b),
        .stb       (adder_b_stb),
        .done      (b_done),
        .xfer      (b_xfer)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: begin
                if (in_xfer) begin
                    if (first_q) begin
                        state_d = in_last ? ST_EMIT : ST_ACCEPT;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (pair_done) begin
                    state_d = ST_WAIT_Z;
                end
            end
            ST_WAIT_Z: begin
                if (z_xfer) begin
                    state_d = last_q ? ST_EMIT : ST_ACCEPT;
                end
            end
            ST_EMIT: begin
                if (sum_xfer) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACCEPT;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                cnt_q <= cnt_inc;
                if (first_q) begin
                    acc_q   <= in_data;
                    first_q <= 1'b0;
                end else begin
                    last_q <= in_last;
                end
            end
            if (z_xfer) begin
                acc_q <= adder_z;
            end
            if (sum_xfer) begin
                first_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_accum_initiator.sv
// Randomised bench for fp_accum_initiator with a cycle-level stb/ack adder model and a
// group-level reference (plain integer sums of integer-valued floats).
module tb_fp_accum_initiator;
    import fp_accum_initiator_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [31:0]      adder_a;
    logic             adder_a_stb;
    logic             adder_a_ack;
    logic [31:0]      adder_b;
    logic             adder_b_stb;
    logic             adder_b_ack;
    logic [31:0]      adder_z;
    logic             adder_z_stb;
    logic             adder_z_ack;
    logic [31:0]      sum_data;
    logic [CNT_W-1:0] sum_count;
    logic             sum_valid;
    logic             sum_ready;

    fp_accum_initiator #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .adder_a     (adder_a),
        .adder_a_stb (adder_a_stb),
        .adder_a_ack (adder_a_ack),
        .adder_b     (adder_b),
        .adder_b_stb (adder_b_stb),
        .adder_b_ack (adder_b_ack),
        .adder_z     (adder_z),
        .adder_z_stb (adder_z_stb),
        .adder_z_ack (adder_z_ack),
        .sum_data    (sum_data),
        .sum_count   (sum_count),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Integer-valued floats only (exact below 2^24).
    function automatic int unsigned fp2int(input logic [31:0] f);
        int unsigned e;
        int unsigned m;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m = {8'd0, 1'b1, f[22:0]};
        return m >> (150 - e);
    endfunction

    function automatic logic [31:0] int2fp(input int unsigned v);
        int p;
        logic [31:0] w;
        if (v == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (v[i]) p = i;
        w = (v << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), w[22:0]};
    endfunction

    // Adder model state.
    int          a_delay = 2, b_delay = 2, z_delay = 3;
    int          a_wait, b_wait, z_wait;
    bit          a_pend, b_pend, a_got, b_got;
    bit          z_active, z_xfer_pend;
    logic [31:0] a_val, b_val, z_val;
    int          pairs_seen = 0, z_xfers = 0, z_aborted = 0, stb_highs = 0;
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    bit          prev_a_stb, prev_a_ack, prev_b_stb, prev_b_ack;
    logic [31:0] prev_a_data, prev_b_data;

    initial begin
        adder_a_ack = 1'b0;
        adder_b_ack = 1'b0;
        adder_z_stb = 1'b0;
        adder_z     = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (z_active) z_aborted++;
                a_wait = 0; b_wait = 0; z_wait = 0;
                a_pend = 0; b_pend = 0; a_got = 0; b_got = 0;
                z_active = 0; z_xfer_pend = 0;
                prev_a_stb = 0; prev_b_stb = 0; prev_a_ack = 0; prev_b_ack = 0;
                adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
            end else begin
                // A raised strobe must stay up with stable data until it transfers, then drop.
                if (prev_a_stb) begin
                    if (prev_a_ack) check_eq("a_stb_drop", 32'(adder_a_stb), 32'd0);
                    else begin
                        check_eq("a_stb_hold", 32'(adder_a_stb), 32'd1);
                        check_eq("a_data_hold", adder_a, prev_a_data);
                    end
                end
                if (prev_b_stb) begin
                    if (prev_b_ack) check_eq("b_stb_drop", 32'(adder_b_stb), 32'd0);
                    else begin
                        check_eq("b_stb_hold", 32'(adder_b_stb), 32'd1);
                        check_eq("b_data_hold", adder_b, prev_b_data);
                    end
                end
                if (adder_a_stb || adder_b_stb) stb_highs++;

                if (a_pend) begin a_pend = 0; a_got = 1; end
                if (b_pend) begin b_pend = 0; b_got = 1; end
                adder_a_ack = 1'b0;
                adder_b_ack = 1'b0;
                if (adder_a_stb && !a_got) begin
                    if (a_wait >= a_delay) begin
                        adder_a_ack = 1'b1; a_pend = 1; a_val = adder_a;
                    end else a_wait++;
                end
                if (adder_b_stb && !b_got) begin
                    if (b_wait >= b_delay) begin
                        adder_b_ack = 1'b1; b_pend = 1; b_val = adder_b;
                    end else b_wait++;
                end

                if (z_xfer_pend) begin
                    z_xfer_pend = 0; z_active = 0; adder_z_stb = 1'b0; z_xfers++;
                end
                if (z_active && !z_xfer_pend) begin
                    if (z_wait >= z_delay) begin
                        adder_z_stb = 1'b1;
                        adder_z     = z_val;
                        if (adder_z_ack) z_xfer_pend = 1;
                    end else z_wait++;
                end

                if (a_got && b_got && !z_active) begin
                    pairs_seen++;
                    if (exp_a_q.size() == 0) check_eq("pair_unexpected", a_val, 32'hFFFF_FFFF);
                    else begin
                        check_eq("pair_a", a_val, exp_a_q.pop_front());
                        check_eq("pair_b", b_val, exp_b_q.pop_front());
                    end
                    z_val    = int2fp(fp2int(a_val) + fp2int(b_val));
                    z_active = 1; z_wait = 0;
                    a_got = 0; b_got = 0; a_wait = 0; b_wait = 0;
                end

                prev_a_stb = adder_a_stb; prev_a_ack = adder_a_ack; prev_a_data = adder_a;
                prev_b_stb = adder_b_stb; prev_b_ack = adder_b_ack; prev_b_data = adder_b;
            end
        end
    end

    logic [31:0] last_sum;

    task automatic send_elem(input logic [31:0] d, input bit last);
        int n;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = $urandom_range(0, 1);
        in_data  = $urandom;
    endtask

    task automatic run_group(input logic [31:0] elems[$], input int hold);
        int unsigned acc_int;
        logic [31:0] acc_bits, exp_sum, hold_data;
        int unsigned exp_cnt;
        int n0, n;
        acc_int  = fp2int(elems[0]);
        acc_bits = elems[0];
        for (int i = 1; i < elems.size(); i++) begin
            exp_a_q.push_back(acc_bits);
            exp_b_q.push_back(elems[i]);
            acc_int += fp2int(elems[i]);
            acc_bits = int2fp(acc_int);
        end
        exp_sum = acc_bits;
        exp_cnt = (elems.size() > CNT_MAX) ? CNT_MAX : elems.size();
        n0 = stb_highs;
        for (int i = 0; i < elems.size(); i++) send_elem(elems[i], i == elems.size() - 1);
        if (elems.size() == 1) begin
            check_eq("single_latency", 32'(sum_valid), 32'd1);
            check_eq("single_no_adder", stb_highs, n0);
        end
        n = 0;
        while (!sum_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("sum_valid", 32'(sum_valid), 32'd1);
        check_eq("sum_data", sum_data, exp_sum);
        check_eq("sum_count", 32'(sum_count), exp_cnt);
        last_sum  = sum_data;
        hold_data = sum_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            check_eq("bp_valid", 32'(sum_valid), 32'd1);
            check_eq("bp_data", sum_data, hold_data);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check_eq("emit_done", 32'(sum_valid), 32'd0);
        check_eq("accept_after_emit", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] g[$];
        int n;
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; sum_ready = 1'b0;
        last_sum = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_stbs", {30'd0, adder_a_stb, adder_b_stb}, 32'd0);
        check_eq("rst_z_ack", 32'(adder_z_ack), 32'd0);
        check_eq("rst_sum_valid", 32'(sum_valid), 32'd0);
        check_eq("rst_sum_data", sum_data, 32'd0);
        check_eq("rst_sum_count", 32'(sum_count), 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        g = '{FP_ONE};
        run_group(g, 0);
        g = '{FP_ONE, FP_TWO, FP_THREE};
        run_group(g, 0);
        check_eq("sum_six", last_sum, FP_SIX);

        // Skewed and simultaneous acks.
        a_delay = 5; b_delay = 1;
        g = '{FP_ONE, FP_TWO, FP_THREE, FP_ONE};
        run_group(g, 0);
        a_delay = 3; b_delay = 3;
        run_group(g, 0);
        a_delay = 0; b_delay = 4;
        run_group(g, 0);
        a_delay = 2; b_delay = 2;

        g = '{FP_TWO, FP_ONE};
        run_group(g, 5);
        g = '{FP_THREE};
        run_group(g, 0);

        g = {};
        repeat (5) g.push_back(FP_ONE);
        run_group(g, 0);
        check_eq("sum_five", last_sum, 32'h40A0_0000);
        g = {};
        repeat (CNT_MAX + 5) g.push_back(FP_ONE);
        a_delay = 0; b_delay = 0; z_delay = 0;
        run_group(g, 0);

        for (int k = 0; k < 30; k++) begin
            int len;
            a_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3);
            z_delay = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            g = {};
            if (len == 1) g.push_back($urandom);
            else for (int i = 0; i < len; i++) g.push_back(int2fp($urandom_range(0, 15)));
            run_group(g, $urandom_range(0, 2));
        end

        // Reset while a z result is pending.
        a_delay = 1; b_delay = 1; z_delay = 50;
        send_elem(FP_ONE, 1'b0);
        exp_a_q.push_back(FP_ONE);
        exp_b_q.push_back(FP_TWO);
        send_elem(FP_TWO, 1'b1);
        n = 0;
        while (!adder_z_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_wait_z", 32'(adder_z_ack), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_stbs", {30'd0, adder_a_stb, adder_b_stb}, 32'd0);
        check_eq("arst_z_ack", 32'(adder_z_ack), 32'd0);
        check_eq("arst_sum_valid", 32'(sum_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_sum_count", 32'(sum_count), 32'd0);
        @(negedge clk);
        exp_a_q.delete();
        exp_b_q.delete();
        z_delay = 3;
        #2 rst = 1'b1;
        @(negedge clk);
        g = '{FP_TWO};
        run_group(g, 0);
        check_eq("post_rst_sum", last_sum, FP_TWO);

        repeat (3) @(negedge clk);
        check_eq("pairs_left", exp_a_q.size(), 0);
        check_eq("z_per_pair", z_xfers + z_aborted, pairs_seen);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
